game_round_ctrl: RTL and testbench
==================================

// Module: game_round_ctrl
// PURPOSE
//  Sequences a multi-round game: start, per-round play, hit/life handling, win/lose, restart.
//  Sits between vga_bitchange (roundWon/collided events, consumes state/roundRst) and the SSD counter (score, timeLeft).
//  Registers all outputs; Start/Ack come from slide switches and are edge-detected internally.
// PARAMETERS
//  NUM_ROUNDS  4    rounds to clear for WIN (1..8)
//  LIVES       3    lives at game start (1..3)
//  ROUND_TIME  60   per-round time limit in secTick units (1..127)
//  ROUND_BONUS 100  score added per cleared round, plus remaining timeLeft
//  SCORE_W     16   score width
// PORTS
//  Clk       in   1        system clock
//  Reset     in   1        synchronous, active-high reset
//  Start     in   1        start switch (level; rising edge used)
//  Ack       in   1        acknowledge switch (level; rising edge used)
//  secTick   in   1        1-cycle timebase enable (1 Hz nominal)
//  roundWon  in   1        level/pulse from datapath: player reached goal
//  collided  in   1        level/pulse from datapath: player hit enemy
//  state     out  6        one-hot {LOSE,WIN,HIT,RDONE,PLAY,INIT}
//  round     out  3        current round index, 0-based
//  lives     out  2        lives remaining
//  timeLeft  out  7        ticks remaining in current round
//  score     out  SCORE_W  accumulated score
//  roundRst  out  1        1-cycle pulse: datapath reloads sprites for new/retried round
// BEHAVIOUR
//  Reset: state=INIT(6'b000001), round=0, lives=LIVES, timeLeft=ROUND_TIME, score=0, roundRst=0.
//  Edge detect: startQ/ackQ reset to 1 -> a switch held high through reset must drop before it counts.
//  INIT: Start edge -> PLAY; round=0, lives=LIVES, score=0, timeLeft=ROUND_TIME, roundRst=1 next cycle.
//  PLAY, per-cycle priority: collided > roundWon > timeout:
//   collided -> HIT, lives-=1.
//   roundWon -> RDONE, score += ROUND_BONUS + timeLeft, saturating at 2^SCORE_W-1.
//   secTick & timeLeft==1 -> timeLeft=0, HIT, lives-=1 (timeout costs a life).
//   secTick otherwise -> timeLeft-=1. timeLeft never wraps below 0.
//   Events in PLAY are ignored during the cycle roundRst is high (datapath still reloading).
//  HIT: Ack edge -> lives==0 ? LOSE : PLAY (same round, timeLeft=ROUND_TIME, roundRst pulse).
//  RDONE: Ack edge -> round==NUM_ROUNDS-1 ? WIN : PLAY (round+=1, timeLeft reload, roundRst pulse).
//  WIN/LOSE: Ack edge -> INIT; score/round/lives held for display until next Start.
//  Start edge outside INIT ignored; Ack edge in INIT/PLAY ignored; roundWon/collided outside PLAY ignored.
//  roundRst exactly 1 cycle, asserted the cycle state first shows PLAY.
//  Reset mid-game: returns to reset values next edge, no roundRst pulse.
//  state always exactly one-hot; illegal encodings recover to INIT next cycle.
// CONFIGURATION
//  GAME_PAUSE_EN defined: adds input Pause (1 bit). In PLAY with Pause=1: timer frozen,
//   roundWon/collided/timeout ignored, state held; other states unaffected.
//  Undefined: no Pause port; PLAY behaves as above unconditionally.
// TESTING
//  Reset, Start 0->1, 4x roundWon at timeLeft=60 with Ack between -> WIN, score=640, round=3.
//  PLAY, collided 3x with Ack after each -> lives 2,1,0, third Ack -> LOSE.
//  PLAY, 60 secTicks, no events -> timeLeft=0, HIT, lives=2; Ack -> PLAY, timeLeft=60, roundRst 1 cycle.
//  collided & roundWon same cycle -> HIT, score unchanged, lives=2.
//  Start held high across Reset -> stays INIT until Start drops and rises; SCORE_W=8 -> score saturates 255.
//  GAME_PAUSE_EN: Pause=1 for 10 secTicks -> timeLeft unchanged, collided ignored; Pause=0 resumes.

Source files
------------

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: multi-round game sequencer.
// Walks INIT -> PLAY -> (RDONE | HIT) -> ... -> WIN | LOSE -> INIT, keeping the
// round index, the remaining lives, the per-round countdown and the score.
// Start and Ack are slide-switch levels; only their rising edges act.
// All outputs are registered.
// Optional feature: define GAME_PAUSE_EN to add a Pause input. While Pause is
// high in PLAY, the timer freezes and round events are ignored.
module game_round_ctrl #(
  parameter int NUM_ROUNDS  = 4,
  parameter int LIVES       = 3,
  parameter int ROUND_TIME  = 60,
  parameter int ROUND_BONUS = 100,
  parameter int SCORE_W     = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Ack,
  input  logic               secTick,
  input  logic               roundWon,
  input  logic               collided,
`ifdef GAME_PAUSE_EN
  input  logic               Pause,
`endif
  output logic [5:0]         state,
  output logic [2:0]         round,
  output logic [1:0]         lives,
  output logic [6:0]         timeLeft,
  output logic [SCORE_W-1:0] score,
  output logic               roundRst
);

  typedef enum logic [5:0] {
    S_INIT  = 6'b000001,
    S_PLAY  = 6'b000010,
    S_RDONE = 6'b000100,
    S_HIT   = 6'b001000,
    S_WIN   = 6'b010000,
    S_LOSE  = 6'b100000
  } state_t;

  localparam logic [2:0] LAST_ROUND = 3'(NUM_ROUNDS - 1);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [6:0] TIME_INIT  = 7'(ROUND_TIME);
  localparam int         SUM_W      = SCORE_W + 9;

  state_t               state_q, state_d;
  logic [2:0]           round_q, round_d;
  logic [1:0]           lives_q, lives_d;
  logic [6:0]           time_q, time_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 round_rst_q, round_rst_d;
  logic                 start_q, start_d;
  logic                 ack_q, ack_d;

  logic                 start_edge;
  logic                 ack_edge;
  logic                 pause_w;
  logic                 play_live;

  // Score update for a cleared round: bonus plus leftover time, clamped at full scale.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [6:0]         t);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(ROUND_BONUS) + SUM_W'(t);
    if (s > SUM_W'({SCORE_W{1'b1}})) return {SCORE_W{1'b1}};
    return s[SCORE_W-1:0];
  endfunction

  // Losing a life never wraps below zero.
  function automatic logic [1:0] dec_life(input logic [1:0] l);
    return (l == 2'd0) ? 2'd0 : l - 2'd1;
  endfunction

`ifdef GAME_PAUSE_EN
  assign pause_w = Pause;
`else
  assign pause_w = 1'b0;
`endif

  // The switch history registers reset high, so a switch that is already up must drop before it counts.
  assign start_edge = Start & ~start_q;
  assign ack_edge   = Ack & ~ack_q;
  // PLAY events are masked while the datapath reloads, which is the cycle roundRst is high, or while paused.
  assign play_live  = ~round_rst_q & ~pause_w;

  // State register, game counters and switch history.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_INIT;
      round_q     <= 3'd0;
      lives_q     <= LIVES_INIT;
      time_q      <= TIME_INIT;
      score_q     <= '0;
      round_rst_q <= 1'b0;
      start_q     <= 1'b1;
      ack_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      lives_q     <= lives_d;
      time_q      <= time_d;
      score_q     <= score_d;
      round_rst_q <= round_rst_d;
      start_q     <= start_d;
      ack_q       <= ack_d;
    end
  end

  // Next-state and counter update. roundRst rises together with every entry into PLAY.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    lives_d     = lives_q;
    time_d      = time_q;
    score_d     = score_q;
    round_rst_d = 1'b0;
    start_d     = Start;
    ack_d       = Ack;
    case (state_q)
      S_INIT: begin
        if (start_edge) begin
          state_d     = S_PLAY;
          round_d     = 3'd0;
          lives_d     = LIVES_INIT;
          score_d     = '0;
          time_d      = TIME_INIT;
          round_rst_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (play_live) begin
          if (collided) begin
            state_d = S_HIT;
            lives_d = dec_life(lives_q);
          end else if (roundWon) begin
            state_d = S_RDONE;
            score_d = sat_add(score_q, time_q);
          end else if (secTick) begin
            if (time_q == 7'd1) begin
              time_d  = 7'd0;
              state_d = S_HIT;
              lives_d = dec_life(lives_q);
            end else if (time_q != 7'd0) begin
              time_d = time_q - 7'd1;
            end
          end
        end
      end
      S_HIT: begin
        if (ack_edge) begin
          if (lives_q == 2'd0) begin
            state_d = S_LOSE;
          end else begin
            state_d     = S_PLAY;
            time_d      = TIME_INIT;
            round_rst_d = 1'b1;
          end
        end
      end
      S_RDONE: begin
        if (ack_edge) begin
          if (round_q == LAST_ROUND) begin
            state_d = S_WIN;
          end else begin
            state_d     = S_PLAY;
            round_d     = round_q + 3'd1;
            time_d      = TIME_INIT;
            round_rst_d = 1'b1;
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (ack_edge) state_d = S_INIT;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign state    = state_q;
  assign round    = round_q;
  assign lives    = lives_q;
  assign timeLeft = time_q;
  assign score    = score_q;
  assign roundRst = round_rst_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl: a default-width instance and an 8-bit-score instance share stimulus.
module tb_game_round_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, Start, Ack, secTick, roundWon, collided;
  logic        Pause;
  logic [5:0]  state, state8;
  logic [2:0]  round, round8;
  logic [1:0]  lives, lives8;
  logic [6:0]  timeLeft, timeLeft8;
  logic [15:0] score;
  logic [7:0]  score8;
  logic        roundRst, roundRst8;

  int nvec = 0;
  int nerr = 0;

  localparam logic [5:0] ST_INIT = 6'b000001, ST_PLAY = 6'b000010, ST_RDONE = 6'b000100,
                         ST_HIT = 6'b001000, ST_WIN = 6'b010000, ST_LOSE = 6'b100000;

  always #5 Clk = ~Clk;

  game_round_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .secTick(secTick),
    .roundWon(roundWon), .collided(collided),
`ifdef GAME_PAUSE_EN
    .Pause(Pause),
`endif
    .state(state), .round(round), .lives(lives), .timeLeft(timeLeft),
    .score(score), .roundRst(roundRst)
  );

  game_round_ctrl #(.SCORE_W(8)) dut8 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .secTick(secTick),
    .roundWon(roundWon), .collided(collided),
`ifdef GAME_PAUSE_EN
    .Pause(Pause),
`endif
    .state(state8), .round(round8), .lives(lives8), .timeLeft(timeLeft8),
    .score(score8), .roundRst(roundRst8)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Idle cycle with the switch low, then one cycle high: guarantees a fresh rising edge.
  task automatic ack_pulse();
    Ack = 1'b0; tick();
    Ack = 1'b1; tick();
    Ack = 1'b0;
  endtask

  task automatic start_pulse();
    Start = 1'b0; tick();
    Start = 1'b1; tick();
    Start = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Ack = 1'b0; secTick = 1'b0;
    roundWon = 1'b0; collided = 1'b0; Pause = 1'b0;
    tick(); tick();
    chk("rst_state", 32'(state), 32'(ST_INIT));
    chk("rst_round", 32'(round), 0);
    chk("rst_lives", 32'(lives), 3);
    chk("rst_time", 32'(timeLeft), 60);
    chk("rst_score", 32'(score), 0);
    chk("rst_roundRst", 32'(roundRst), 0);
    Reset = 1'b0;

    // Four cleared rounds at full time -> WIN with 640 points.
    start_pulse();
    chk("start_state", 32'(state), 32'(ST_PLAY));
    chk("start_roundRst", 32'(roundRst), 1);
    tick();
    chk("start_roundRst_drop", 32'(roundRst), 0);
    for (int r = 0; r < 4; r++) begin
      roundWon = 1'b1; tick(); roundWon = 1'b0;
      chk("rdone_state", 32'(state), 32'(ST_RDONE));
      chk("rdone_score", 32'(score), 32'((r + 1) * 160));
      if (r == 0) chk("sat8_first", 32'(score8), 160);
      collided = 1'b1; tick(); collided = 1'b0;
      chk("rdone_ignores_collided", 32'(lives), 3);
      ack_pulse();
      if (r < 3) begin
        chk("next_state", 32'(state), 32'(ST_PLAY));
        chk("next_round", 32'(round), 32'(r + 1));
        chk("next_roundRst", 32'(roundRst), 1);
        chk("next_time", 32'(timeLeft), 60);
        tick();
      end else begin
        chk("win_state", 32'(state), 32'(ST_WIN));
        chk("win_round", 32'(round), 3);
        chk("win_score", 32'(score), 640);
        chk("sat8_score", 32'(score8), 255);
      end
    end
    ack_pulse();
    chk("win_to_init", 32'(state), 32'(ST_INIT));
    chk("init_score_held", 32'(score), 640);

    // Three collisions -> LOSE.
    start_pulse();
    chk("g2_score_clear", 32'(score), 0);
    chk("g2_lives", 32'(lives), 3);
    tick();
    for (int k = 0; k < 3; k++) begin
      collided = 1'b1; tick(); collided = 1'b0;
      chk("hit_state", 32'(state), 32'(ST_HIT));
      chk("hit_lives", 32'(lives), 32'(2 - k));
      ack_pulse();
      if (k < 2) begin
        chk("retry_state", 32'(state), 32'(ST_PLAY));
        chk("retry_roundRst", 32'(roundRst), 1);
        tick();
      end else begin
        chk("lose_state", 32'(state), 32'(ST_LOSE));
      end
    end
    ack_pulse();
    chk("lose_to_init", 32'(state), 32'(ST_INIT));
    chk("lose_lives_held", 32'(lives), 0);

    // Timeout: 60 ticks with no events.
    start_pulse();
    tick();
    secTick = 1'b1;
    for (int i = 0; i < 59; i++) tick();
    chk("tmo_time1", 32'(timeLeft), 1);
    chk("tmo_still_play", 32'(state), 32'(ST_PLAY));
    tick();
    secTick = 1'b0;
    chk("tmo_time0", 32'(timeLeft), 0);
    chk("tmo_state", 32'(state), 32'(ST_HIT));
    chk("tmo_lives", 32'(lives), 2);
    ack_pulse();
    chk("tmo_retry_state", 32'(state), 32'(ST_PLAY));
    chk("tmo_retry_time", 32'(timeLeft), 60);
    chk("tmo_retry_roundRst", 32'(roundRst), 1);
    tick();
    chk("tmo_roundRst_1cyc", 32'(roundRst), 0);

    // Reset mid-game.
    Reset = 1'b1; tick(); Reset = 1'b0;
    chk("midrst_state", 32'(state), 32'(ST_INIT));
    chk("midrst_lives", 32'(lives), 3);
    chk("midrst_roundRst", 32'(roundRst), 0);

    // Simultaneous collided and roundWon: the collision wins.
    start_pulse();
    tick();
    collided = 1'b1; roundWon = 1'b1; tick();
    collided = 1'b0; roundWon = 1'b0;
    chk("both_state", 32'(state), 32'(ST_HIT));
    chk("both_score", 32'(score), 0);
    chk("both_lives", 32'(lives), 2);

    // Start held high through reset does not start a game.
    Start = 1'b1; Reset = 1'b1; tick(); Reset = 1'b0;
    tick(); tick();
    chk("held_start_init", 32'(state), 32'(ST_INIT));
    Start = 1'b0; tick();
    Start = 1'b1; tick();
    chk("held_start_play", 32'(state), 32'(ST_PLAY));
    // Collision during the reload cycle is ignored.
    collided = 1'b1; tick(); collided = 1'b0;
    Start = 1'b0;
    chk("reload_ignores_state", 32'(state), 32'(ST_PLAY));
    chk("reload_ignores_lives", 32'(lives), 3);

`ifdef GAME_PAUSE_EN
    Pause = 1'b1; secTick = 1'b1; collided = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    collided = 1'b0;
    chk("pause_time", 32'(timeLeft), 60);
    chk("pause_state", 32'(state), 32'(ST_PLAY));
    chk("pause_lives", 32'(lives), 3);
    Pause = 1'b0; tick(); secTick = 1'b0;
    chk("resume_time", 32'(timeLeft), 59);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
